mux_rr_arbiter: RTL

// - Shares one 2:1 data multiplexer between two requesters. Each requester

---
 rtl/mux_rr_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with bounded hold that owns a 2:1 mux select
//
// Purpose: two requesters share one 2:1 data mux. A three-state FSM
// (IDLE, G0, G1) grants the mux round-robin. The current owner keeps the mux
// for at most MAX_HOLD consecutive cycles while the other side is waiting.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req0/req1  in   requests from requester 0/1
//   i0/i1      in   WIDTH-bit data from requester 0/1
//   gnt0/gnt1  out  grants, decoded straight from the state register
//   s          out  mux select (1 = i1), decoded from the state register
//   out        out  selected data, 0 when idle
//   out_valid  out  gnt0 | gnt1

module mux_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   hold_cnt;
    logic [CW-1:0]   hold_cnt_nx;
    logic            last;
    logic            last_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;   // requester 0 wins the first tie
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            last     <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req0 && !req1)      state_nx = G0;
                else if (req1 && !req0) state_nx = G1;
                else if (req0 && req1)  state_nx = last ? G0 : G1;
                else                    state_nx = IDLE;
            end
            G0: begin
                if (!req0)                          state_nx = req1 ? G1 : IDLE;
                else if (req1 && hold_cnt == HOLD_MAX) state_nx = G1;
                else                                state_nx = G0;
            end
            G1: begin
                if (!req1)                          state_nx = req0 ? G0 : IDLE;
                else if (req0 && hold_cnt == HOLD_MAX) state_nx = G0;
                else                                state_nx = G1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counter restarts on every new owner (including a direct switch) and
    // saturates so an uncontested owner can hold the mux indefinitely.
    always_comb begin
        hold_cnt_nx = hold_cnt;
        last_nx     = last;
        if (state_nx != state) begin
            hold_cnt_nx = '0;
            if (state_nx == G0) last_nx = 1'b0;
            if (state_nx == G1) last_nx = 1'b1;
        end else if (state != IDLE && hold_cnt != HOLD_MAX) begin
            hold_cnt_nx = hold_cnt + 1'b1;
        end
    end

    assign gnt0      = (state == G0);
    assign gnt1      = (state == G1);
    assign s         = (state == G1);
    assign out_valid = gnt0 | gnt1;
    assign out       = (state == IDLE) ? '0 : (s ? i1 : i0);

endmodule
